// File: rtl/bus_master.sv
// Single-outstanding master for the 16-bit local slave bus.
// Turns valid/ready host requests into bus cycles and returns data or a timeout error.
module bus_master #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int TIMEOUT = 16,
  parameter logic [ADDR_W-1:0] IDLE_ADDR = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic [ADDR_W-1:0] addr_bus,
  output logic [DATA_W-1:0] data_bus,
  output logic              rw,
  output logic              data_strobe,
  input  logic              address_valid,
  input  logic [DATA_W-1:0] data_bus_i
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, XFER, RSP} state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] data_n, rdata_n;
  logic              rw_n, strobe_n, rsp_valid_n, err_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      addr_bus    <= IDLE_ADDR;
      data_bus    <= '0;
      rw          <= 1'b0;
      data_strobe <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_error   <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      addr_bus    <= addr_n;
      data_bus    <= data_n;
      rw          <= rw_n;
      data_strobe <= strobe_n;
      rsp_valid   <= rsp_valid_n;
      rsp_rdata   <= rdata_n;
      rsp_error   <= err_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    addr_n      = addr_bus;
    data_n      = data_bus;
    rw_n        = rw;
    strobe_n    = data_strobe;
    rsp_valid_n = rsp_valid;
    rdata_n     = rsp_rdata;
    err_n       = rsp_error;
    // a new cycle must wait until the previous slave has dropped its ack
    req_ready   = (state == IDLE) && !address_valid;

    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          addr_n  = req_addr;
          rw_n    = req_write;
          data_n  = req_write ? req_wdata : '0;
          cnt_n   = '0;
          state_n = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (address_valid) begin
          strobe_n = rw;
          state_n  = XFER;
        end else if (cnt == CNT_LAST) begin
          err_n       = 1'b1;
          rdata_n     = '0;
          rsp_valid_n = 1'b1;
          addr_n      = IDLE_ADDR;
          rw_n        = 1'b0;
          data_n      = '0;
          state_n     = RSP;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      XFER: begin
        strobe_n    = 1'b0;
        rdata_n     = rw ? '0 : data_bus_i;
        err_n       = 1'b0;
        rsp_valid_n = 1'b1;
        addr_n      = IDLE_ADDR;
        rw_n        = 1'b0;
        data_n      = '0;
        state_n     = RSP;
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_n = 1'b0;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
